// File: rtl/arbiter_n_to_1_credit_scheduler_pkg.sv
// Shared types and helpers for the N-to-1 credit-gated weighted round-robin scheduler.
// Holds the FSM state encoding and the per-requester credit-counter width rule.
package arbiter_n_to_1_credit_scheduler_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE      = 2'd0,
    SCHED_ARBITRATE = 2'd1,
    SCHED_BURST     = 2'd2
  } scheduler_state_e;

  localparam int DEFAULT_MAX_CREDITS = 32;

  // Counter must hold the value MAX itself, hence the +1.
  function automatic int credit_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

  localparam int DEFAULT_CREDIT_WIDTH = credit_width(DEFAULT_MAX_CREDITS);

endpackage

// File: rtl/arbiter_n_to_1_credit_scheduler_credit_counter_saturating.sv
// Per-requester outstanding-request credit counter: one credit spent per issue,
// one returned per response; a return at MAX saturates and raises a sticky error.
module credit_counter_saturating
  import arbiter_n_to_1_credit_scheduler_pkg::*;
#(
  parameter int MAX_CREDITS  = DEFAULT_MAX_CREDITS,
  parameter int CREDIT_WIDTH = credit_width(MAX_CREDITS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    inc_i,
  input  logic                    dec_i,
  output logic [CREDIT_WIDTH-1:0] count_o,
  output logic                    nonzero_o,
  output logic                    error_o
);

  localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] ONE_C = CREDIT_WIDTH'(1);

  logic [CREDIT_WIDTH-1:0] count_q, count_d;
  logic                    nonzero_q;
  logic                    error_q, error_d;

  // Simultaneous inc and dec cancel, so they fall into the default arm.
  always_comb begin
    count_d = count_q;
    error_d = error_q;
    case ({inc_i, dec_i})
      2'b10: begin
        if (count_q == MAX_C) begin
          error_d = 1'b1;
        end else begin
          count_d = count_q + ONE_C;
        end
      end
      2'b01: begin
        if (count_q != '0) begin
          count_d = count_q - ONE_C;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= MAX_C;
      nonzero_q <= 1'b1;
      error_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      nonzero_q <= (count_d != '0);
      error_q   <= error_d;
    end
  end

  assign count_o   = count_q;
  assign nonzero_o = nonzero_q;
  assign error_o   = error_q;

endmodule

// File: rtl/arbiter_n_to_1_credit_scheduler.sv
// Weighted round-robin pop scheduler: each owner holds the shared path for up to
// its burst quota, issuing only while it has a request pending and credits left.
module arbiter_n_to_1_credit_scheduler
  import arbiter_n_to_1_credit_scheduler_pkg::*;
#(
  parameter int NUM_MEMORY_REQUESTOR  = 2,
  parameter int NUM_ARBITER_REQUESTOR = 2 ** $clog2(NUM_MEMORY_REQUESTOR),
  parameter int WEIGHT_WIDTH          = 4,
  parameter int MAX_CREDITS           = DEFAULT_MAX_CREDITS,
  parameter int CREDIT_WIDTH          = credit_width(MAX_CREDITS),
  localparam int IDX_W = (NUM_ARBITER_REQUESTOR > 1) ? $clog2(NUM_ARBITER_REQUESTOR) : 1
) (
  input  logic                                         ap_clk,
  input  logic                                         areset,
  input  logic [NUM_MEMORY_REQUESTOR*WEIGHT_WIDTH-1:0] config_weight_in,
  input  logic [NUM_MEMORY_REQUESTOR-1:0]              request_pending_in,
  input  logic                                         downstream_ready_in,
  input  logic [NUM_MEMORY_REQUESTOR-1:0]              response_return_in,
  output logic [NUM_MEMORY_REQUESTOR-1:0]              arbiter_grant_out,
  output logic [IDX_W-1:0]                             active_requestor_out,
  output logic [NUM_MEMORY_REQUESTOR-1:0]              credit_available_out,
  output logic                                         scheduler_idle_out,
  output logic                                         credit_error_out,
  output logic [1:0]                                   scheduler_state_out
);

  localparam int N  = NUM_MEMORY_REQUESTOR;
  localparam int NA = NUM_ARBITER_REQUESTOR;
  localparam logic [WEIGHT_WIDTH-1:0] W_ONE = WEIGHT_WIDTH'(1);

  // Handshake: arbiter_grant_out[i] is a one-cycle pop; an issue happens only in
  // a cycle where the owner is eligible and downstream_ready_in is high.

  scheduler_state_e          state_q, state_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [IDX_W-1:0]          last_owner_q, last_owner_d;
  logic [WEIGHT_WIDTH-1:0]   burst_count_q, burst_count_d;
  logic [N-1:0]              grant_q, grant_d;
  logic                      idle_q;

  logic [CREDIT_WIDTH-1:0]   credits [N];
  logic [N-1:0]              counter_error;
  logic [N-1:0]              eligible;
  logic [NA-1:0]             eligible_pad;
  logic                      rr_found;
  logic [IDX_W-1:0]          rr_idx;
  logic [WEIGHT_WIDTH-1:0]   rr_weight;
  logic [WEIGHT_WIDTH-1:0]   rr_weight_eff;
  logic                      owner_eligible;
  logic                      issue;

  for (genvar g = 0; g < N; g++) begin : g_credit
    credit_counter_saturating #(
      .MAX_CREDITS  (MAX_CREDITS),
      .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_credit (
      .clk_i     (ap_clk),
      .rst_i     (areset),
      .inc_i     (response_return_in[g]),
      .dec_i     (grant_d[g]),
      .count_o   (credits[g]),
      .nonzero_o (credit_available_out[g]),
      .error_o   (counter_error[g])
    );
  end

  always_comb begin
    eligible     = '0;
    eligible_pad = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i]     = request_pending_in[i] && (credits[i] != '0);
      eligible_pad[i] = eligible[i];
    end
  end

  // Search starts one past the last owner; NA is a power of two so the add wraps.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int off = 1; off <= NA; off++) begin
      if (!rr_found && eligible_pad[last_owner_q + IDX_W'(off)]) begin
        rr_found = 1'b1;
        rr_idx   = last_owner_q + IDX_W'(off);
      end
    end
  end

  always_comb begin
    rr_weight = '0;
    for (int i = 0; i < N; i++) begin
      if (rr_idx == IDX_W'(i)) begin
        rr_weight = config_weight_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
    rr_weight_eff = (rr_weight == '0) ? W_ONE : rr_weight;
  end

  assign owner_eligible = eligible_pad[owner_q];
  assign issue = (state_q == SCHED_BURST) && owner_eligible &&
                 downstream_ready_in && (burst_count_q != '0);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    burst_count_d = burst_count_q;
    grant_d       = '0;
    case (state_q)
      SCHED_IDLE: begin
        if (|eligible) begin
          state_d = SCHED_ARBITRATE;
        end
      end
      SCHED_ARBITRATE: begin
        if (rr_found) begin
          owner_d       = rr_idx;
          last_owner_d  = rr_idx;
          burst_count_d = rr_weight_eff;
          state_d       = SCHED_BURST;
        end else begin
          state_d = SCHED_IDLE;
        end
      end
      SCHED_BURST: begin
        if (issue) begin
          for (int i = 0; i < N; i++) begin
            grant_d[i] = (owner_q == IDX_W'(i));
          end
          burst_count_d = burst_count_q - W_ONE;
          if (burst_count_q == W_ONE) begin
            state_d = SCHED_ARBITRATE;
          end
        end else if (!owner_eligible || (burst_count_q == '0)) begin
          // Owner yields; a stalled-but-eligible owner keeps the path instead.
          state_d = SCHED_ARBITRATE;
        end
      end
      default: begin
        state_d = SCHED_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q       <= SCHED_IDLE;
      owner_q       <= '0;
      last_owner_q  <= IDX_W'(N - 1);
      burst_count_q <= '0;
      grant_q       <= '0;
      idle_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      burst_count_q <= burst_count_d;
      grant_q       <= grant_d;
      idle_q        <= (state_d == SCHED_IDLE);
    end
  end

  assign arbiter_grant_out    = grant_q;
  assign active_requestor_out = owner_q;
  assign scheduler_idle_out   = idle_q;
  assign credit_error_out     = |counter_error;
  assign scheduler_state_out  = state_q;

endmodule

// File: tb/tb_arbiter_n_to_1_credit_scheduler.sv
// Directed bench for the credit scheduler: N=2, MAX_CREDITS=4, hand-computed
// grant sequences checked one cycle at a time just after each rising edge.
module tb_arbiter_n_to_1_credit_scheduler;

  logic       ap_clk = 1'b0;
  logic       areset;
  logic [7:0] config_weight_in;
  logic [1:0] request_pending_in;
  logic       downstream_ready_in;
  logic [1:0] response_return_in;
  logic [1:0] arbiter_grant_out;
  logic [0:0] active_requestor_out;
  logic [1:0] credit_available_out;
  logic       scheduler_idle_out;
  logic       credit_error_out;
  logic [1:0] scheduler_state_out;

  int total = 0;
  int bad   = 0;
  int gcount;

  logic [1:0] t2_grant [13] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                                2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
  logic       t2_owner [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] t3_grant [8]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
  logic [1:0] t3_tail  [5]  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
  logic [1:0] t6_grant [9]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};

  arbiter_n_to_1_credit_scheduler #(
    .NUM_MEMORY_REQUESTOR (2),
    .WEIGHT_WIDTH         (4),
    .MAX_CREDITS          (4)
  ) dut (
    .ap_clk               (ap_clk),
    .areset               (areset),
    .config_weight_in     (config_weight_in),
    .request_pending_in   (request_pending_in),
    .downstream_ready_in  (downstream_ready_in),
    .response_return_in   (response_return_in),
    .arbiter_grant_out    (arbiter_grant_out),
    .active_requestor_out (active_requestor_out),
    .credit_available_out (credit_available_out),
    .scheduler_idle_out   (scheduler_idle_out),
    .credit_error_out     (credit_error_out),
    .scheduler_state_out  (scheduler_state_out)
  );

  // clock/reset block
  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    areset              = 1'b1;
    config_weight_in    = 8'h00;
    request_pending_in  = 2'b00;
    downstream_ready_in = 1'b1;
    response_return_in  = 2'b00;
    tick();
    tick();
    chk("rst_grant", arbiter_grant_out, 2'b00);
    chk("rst_idle", scheduler_idle_out, 1'b1);
    chk("rst_avail", credit_available_out, 2'b11);
    chk("rst_err", credit_error_out, 1'b0);
    chk("rst_owner", active_requestor_out, 1'b0);
    chk("rst_state", scheduler_state_out, 2'd0);

    // Weighted round robin, w0=2 w1=3, returns echo each grant one cycle later.
    areset             = 1'b0;
    config_weight_in   = {4'd3, 4'd2};
    request_pending_in = 2'b11;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("wrr_grant[%0d]", i), arbiter_grant_out, t2_grant[i]);
      chk($sformatf("wrr_owner[%0d]", i), active_requestor_out, t2_owner[i]);
      if (i == 0) chk("wrr_not_idle", scheduler_idle_out, 1'b0);
      response_return_in = t2_grant[i];
    end
    request_pending_in = 2'b00;
    tick();
    chk("wrr_drop_grant", arbiter_grant_out, 2'b00);
    response_return_in = 2'b00;
    tick();
    tick();
    tick();
    chk("wrr_idle", scheduler_idle_out, 1'b1);
    chk("wrr_avail", credit_available_out, 2'b11);
    chk("wrr_err", credit_error_out, 1'b0);

    // Credit exhaustion: only requester 0, w0=8, no returns.
    config_weight_in   = {4'd0, 4'd8};
    request_pending_in = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("exh_grant[%0d]", i), arbiter_grant_out, t3_grant[i]);
    end
    chk("exh_avail", credit_available_out, 2'b10);
    chk("exh_idle", scheduler_idle_out, 1'b1);
    response_return_in = 2'b01;
    tick();
    chk("exh_ret_avail", credit_available_out, 2'b11);
    chk("exh_ret_grant", arbiter_grant_out, 2'b00);
    response_return_in = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("exh_tail[%0d]", i), arbiter_grant_out, t3_tail[i]);
    end
    chk("exh_tail_idle", scheduler_idle_out, 1'b1);
    request_pending_in = 2'b00;
    response_return_in = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    response_return_in = 2'b00;
    chk("exh_restore", credit_available_out, 2'b11);
    chk("exh_err", credit_error_out, 1'b0);

    // Downstream backpressure mid-burst: w0=4, ready low after 2nd grant.
    config_weight_in   = {4'd3, 4'd4};
    request_pending_in = 2'b01;
    tick();
    chk("bp_g0", arbiter_grant_out, 2'b00);
    tick();
    chk("bp_g1", arbiter_grant_out, 2'b00);
    tick();
    chk("bp_g2", arbiter_grant_out, 2'b01);
    tick();
    chk("bp_g3", arbiter_grant_out, 2'b01);
    downstream_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_stall_grant[%0d]", i), arbiter_grant_out, 2'b00);
      chk($sformatf("bp_stall_owner[%0d]", i), active_requestor_out, 1'b0);
      chk($sformatf("bp_stall_state[%0d]", i), scheduler_state_out, 2'd2);
    end
    downstream_ready_in = 1'b1;
    tick();
    chk("bp_g4", arbiter_grant_out, 2'b01);
    tick();
    chk("bp_g5", arbiter_grant_out, 2'b01);
    chk("bp_arb_state", scheduler_state_out, 2'd1);
    tick();
    chk("bp_g6", arbiter_grant_out, 2'b00);
    chk("bp_idle", scheduler_idle_out, 1'b1);
    request_pending_in = 2'b00;
    response_return_in = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    response_return_in = 2'b00;
    chk("bp_restore", credit_available_out, 2'b11);

    // Return at MAX on requester 1: saturate and latch the error.
    response_return_in = 2'b10;
    tick();
    response_return_in = 2'b00;
    chk("sat_err", credit_error_out, 1'b1);
    chk("sat_avail", credit_available_out, 2'b11);
    config_weight_in   = {4'd8, 4'd4};
    request_pending_in = 2'b10;
    gcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (arbiter_grant_out == 2'b10) gcount++;
      chk($sformatf("sat_no_g0[%0d]", i), arbiter_grant_out[0], 1'b0);
    end
    chk("sat_grant_count", gcount, 4);
    chk("sat_avail_empty", credit_available_out, 2'b01);
    chk("sat_err_hold", credit_error_out, 1'b1);
    request_pending_in = 2'b00;
    response_return_in = 2'b10;
    for (int i = 0; i < 4; i++) tick();
    response_return_in = 2'b00;
    chk("sat_restore", credit_available_out, 2'b11);
    chk("sat_err_sticky", credit_error_out, 1'b1);

    // Reset mid-burst after 1 of 3 grants.
    config_weight_in   = {4'd1, 4'd3};
    request_pending_in = 2'b01;
    tick();
    tick();
    tick();
    chk("mid_g0", arbiter_grant_out, 2'b01);
    areset             = 1'b1;
    config_weight_in   = {4'd1, 4'd8};
    request_pending_in = 2'b11;
    tick();
    chk("mid_rst_grant", arbiter_grant_out, 2'b00);
    chk("mid_rst_idle", scheduler_idle_out, 1'b1);
    chk("mid_rst_owner", active_requestor_out, 1'b0);
    chk("mid_rst_err", credit_error_out, 1'b0);
    chk("mid_rst_avail", credit_available_out, 2'b11);
    chk("mid_rst_state", scheduler_state_out, 2'd0);
    areset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("post_rst_grant[%0d]", i), arbiter_grant_out, t6_grant[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
